// File: rtl/button_press_pulse_pkg.sv
// Shared defaults and helpers for the button press pulse generator.
// Every instance takes its parameter defaults from here so one place tunes them all.
package btn_pkg;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 0;
    localparam int DEF_LONG_CYCLES     = 0;

    // Width of a counter that must hold values 0..n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/button_press_pulse_if.sv
// Button-side signal bundle: raw level in, filtered level and event pulses out.
// master drives the raw level; slave is the pulse generator.
interface button_press_pulse_if;

    logic in;
    logic out;
    logic release_pulse;
    logic level;
    logic long_press;

    modport master (
        output in,
        input  out,
        input  release_pulse,
        input  level,
        input  long_press
    );

    modport slave (
        input  in,
        output out,
        output release_pulse,
        output level,
        output long_press
    );

endinterface

// File: rtl/button_press_pulse_edge_sync.sv
// Multi-flop synchronizer for a single asynchronous level.
// Pure flop chain, nothing combinational between stages, so metastability can settle.
module edge_sync
    import btn_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], d};
        end
    end

    assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/button_press_pulse.sv
// Turns a slow, possibly bouncy button level into single-cycle press, release
// and long-press pulses in the clk domain.
module button_press_pulse
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    button_press_pulse_if.slave  btn
);

    logic s;
    logic level_reg;
    logic lvl_q_reg;
    logic out_reg;
    logic release_reg;
    logic long_reg;

    edge_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn.in),
        .q     (s)
    );

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_filter_bypass
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    level_reg <= 1'b0;
                end else begin
                    level_reg <= s;
                end
            end
        end else begin : g_filter_debounce
            localparam int              DW      = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [DW-1:0]   DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

            logic [DW-1:0] db_cnt_reg;

            // Level only follows s after N consecutive disagreeing cycles; any agreement restarts the count.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    level_reg  <= 1'b0;
                    db_cnt_reg <= '0;
                end else if (s == level_reg) begin
                    db_cnt_reg <= '0;
                end else if (db_cnt_reg == DB_LAST) begin
                    level_reg  <= s;
                    db_cnt_reg <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + DW'(1);
                end
            end
        end
    endgenerate

    // Registered edge detect; the two pulses are mutually exclusive by construction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lvl_q_reg   <= 1'b0;
            out_reg     <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            lvl_q_reg   <= level_reg;
            out_reg     <= level_reg & ~lvl_q_reg;
            release_reg <= ~level_reg & lvl_q_reg;
        end
    end

    generate
        if (LONG_CYCLES == 0) begin : g_long_off
            assign long_reg = 1'b0;
        end else begin : g_long_on
            localparam int            LW      = cnt_width(LONG_CYCLES);
            localparam logic [LW-1:0] LP_MAX  = LW'(LONG_CYCLES);
            localparam logic [LW-1:0] LP_FIRE = LW'(LONG_CYCLES - 1);

            logic [LW-1:0] hold_cnt_reg;
            logic          long_pulse_reg;

            // Counter parks at LONG_CYCLES so the pulse fires once per press.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    hold_cnt_reg   <= '0;
                    long_pulse_reg <= 1'b0;
                end else if (!level_reg) begin
                    hold_cnt_reg   <= '0;
                    long_pulse_reg <= 1'b0;
                end else if (hold_cnt_reg != LP_MAX) begin
                    hold_cnt_reg   <= hold_cnt_reg + LW'(1);
                    long_pulse_reg <= (hold_cnt_reg == LP_FIRE);
                end else begin
                    long_pulse_reg <= 1'b0;
                end
            end

            assign long_reg = long_pulse_reg;
        end
    endgenerate

    assign btn.out           = out_reg;
    assign btn.release_pulse = release_reg;
    assign btn.level         = level_reg;
    assign btn.long_press    = long_reg;

endmodule

// File: tb/tb_button_press_pulse.sv
// Directed bench for button_press_pulse with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
// Pulse positions are counted in clock edges from the first edge after the input changes.
module tb_button_press_pulse;

    logic clk = 1'b0;
    logic reset;

    button_press_pulse_if bif();

    button_press_pulse #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int cyc;
    int out_cnt, out_first;
    int rel_cnt, rel_first;
    int long_cnt, long_first;
    int level_cnt;
    int both_cnt;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        cyc        = 0;
        out_cnt    = 0;
        out_first  = -1;
        rel_cnt    = 0;
        rel_first  = -1;
        long_cnt   = 0;
        long_first = -1;
        level_cnt  = 0;
        both_cnt   = 0;
    endtask

    // One clock edge, then sample outputs 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (bif.out === 1'b1) begin
            out_cnt++;
            if (out_first < 0) out_first = cyc;
        end
        if (bif.release_pulse === 1'b1) begin
            rel_cnt++;
            if (rel_first < 0) rel_first = cyc;
        end
        if (bif.long_press === 1'b1) begin
            long_cnt++;
            if (long_first < 0) long_first = cyc;
        end
        if (bif.level === 1'b1) level_cnt++;
        if (bif.out === 1'b1 && bif.release_pulse === 1'b1) both_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic report(input string name);
        $display("%s: out=%0d@%0d release=%0d@%0d long=%0d@%0d level=%0d", name,
                 out_cnt, out_first, rel_cnt, rel_first, long_cnt, long_first, bif.level);
    endtask

    initial begin
        reset  = 1'b0;
        bif.in = 1'b0;

        // Held in reset while the input toggles: nothing may move.
        clear_stats();
        for (int i = 0; i < 8; i++) begin
            bif.in = ((i % 2) == 1);
            cycle();
        end
        report("reset_hold");
        check("rst_out",     out_cnt,   0);
        check("rst_release", rel_cnt,   0);
        check("rst_level",   level_cnt, 0);
        check("rst_long",    long_cnt,  0);

        bif.in = 1'b0;
        reset  = 1'b1;
        clear_stats();
        run(5);
        report("idle");
        check("idle_level", level_cnt, 0);

        // Clean press held for 40 cycles; level rises at edge 6, long press 16 edges later.
        clear_stats();
        bif.in = 1'b1;
        run(40);
        report("clean_press");
        check("press_out_cnt",     out_cnt,    1);
        check("press_out_first",   out_first,  7);
        check("press_release_cnt", rel_cnt,    0);
        check("press_level",       int'(bif.level), 1);
        check("long_cnt",          long_cnt,   1);
        check("long_first",        long_first, 22);
        check("press_no_overlap",  both_cnt,   0);

        clear_stats();
        bif.in = 1'b0;
        run(20);
        report("release");
        check("rel_cnt",     rel_cnt,   1);
        check("rel_first",   rel_first, 7);
        check("rel_out_cnt", out_cnt,   0);
        check("rel_long",    long_cnt,  0);
        check("rel_level",   int'(bif.level), 0);

        // Three-cycle glitch is rejected; the steady run after it is accepted.
        clear_stats();
        bif.in = 1'b1;
        run(3);
        bif.in = 1'b0;
        run(2);
        bif.in = 1'b1;
        run(20);
        report("bounce");
        check("bounce_out_cnt",   out_cnt,   1);
        check("bounce_out_first", out_first, 12);

        clear_stats();
        bif.in = 1'b0;
        run(20);
        report("bounce_release");
        check("bounce_rel_cnt", rel_cnt, 1);

        // Reset while the press pulse is high, input kept pressed throughout.
        clear_stats();
        bif.in = 1'b1;
        run(7);
        check("pre_reset_out", int'(bif.out), 1);
        reset = 1'b0;
        #1;
        check("async_out",   int'(bif.out),   0);
        check("async_level", int'(bif.level), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear_stats();
        run(30);
        report("after_reset");
        check("rearm_out_cnt",   out_cnt,    1);
        check("rearm_out_first", out_first,  7);
        check("rearm_long_cnt",  long_cnt,   1);
        check("rearm_long_first", long_first, 22);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
